secure_boot_sequencer: RTL



---
 rtl/secure_boot_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/secure_boot_sequencer.sv
// Secure boot: streams NUM_WORDS firmware words, sums them mod 2**DATA_W, checks against trusted_sig with retries.
// Latency: 2 cycles/word with a 1-cycle ROM plus CHECK; the ROM cannot stall beyond TIMEOUT WAIT cycles per read.
module secure_boot_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16,
    parameter int MAX_RETRY = 2,
    parameter int RETRY_W   = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               power_on,
    input  logic [DATA_W-1:0]  trusted_sig,
    output logic               fw_rd_en,
    output logic [ADDR_W-1:0]  fw_addr,
    input  logic               fw_rd_valid,
    input  logic [DATA_W-1:0]  fw_rd_data,
    output logic               boot_busy,
    output logic               boot_ok,
    output logic               boot_fail,
    output logic [RETRY_W-1:0] attempt_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_RETRY, S_PASS, S_LOCK
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_sum, w_sum_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic [TMR_W-1:0]    r_timer, w_timer_nxt;
    logic [RETRY_W-1:0]  r_attempt, w_attempt_nxt;
    logic                r_rd_en, w_rd_en_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_ok, w_ok_nxt;
    logic                r_fail, w_fail_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sum     <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_attempt <= '0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_ok      <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sum     <= w_sum_nxt;
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_attempt <= w_attempt_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_addr    <= w_addr_nxt;
            r_busy    <= w_busy_nxt;
            r_ok      <= w_ok_nxt;
            r_fail    <= w_fail_nxt;
        end
    end

    // Dropping power_on aborts any in-flight attempt; LOCKOUT ignores it entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (power_on) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = power_on ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!power_on)
                    w_state_nxt = S_IDLE;
                else if (fw_rd_valid)
                    w_state_nxt = (r_idx == LAST_IDX) ? S_CHECK : S_FETCH;
                else if (r_timer == TMR_LAST)
                    w_state_nxt = S_RETRY;
            end
            S_CHECK: begin
                if (!power_on)
                    w_state_nxt = S_IDLE;
                else
                    w_state_nxt = (r_sum == trusted_sig) ? S_PASS : S_RETRY;
            end
            S_RETRY: begin
                if (!power_on)
                    w_state_nxt = S_IDLE;
                else
                    w_state_nxt = (r_attempt < RETRY_LIM) ? S_FETCH : S_LOCK;
            end
            S_PASS:  if (!power_on) w_state_nxt = S_IDLE;
            S_LOCK:  w_state_nxt = S_LOCK;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        w_sum_nxt     = r_sum;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        w_attempt_nxt = r_attempt;
        case (r_state)
            S_IDLE: begin
                w_sum_nxt   = '0;
                w_idx_nxt   = '0;
                w_timer_nxt = '0;
            end
            S_FETCH: w_timer_nxt = '0;
            S_WAIT: begin
                if (fw_rd_valid) begin
                    w_sum_nxt = r_sum + fw_rd_data;
                    if (r_idx != LAST_IDX)
                        w_idx_nxt = r_idx + 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_RETRY: begin
                if (w_state_nxt == S_FETCH) begin
                    w_attempt_nxt = r_attempt + 1'b1;
                    w_sum_nxt     = '0;
                    w_idx_nxt     = '0;
                end
            end
            default: ;
        endcase
        if (w_state_nxt == S_PASS)
            w_attempt_nxt = '0;

        w_rd_en_nxt = (w_state_nxt == S_FETCH);
        w_addr_nxt  = (w_state_nxt == S_FETCH) ? w_idx_nxt : '0;
        w_busy_nxt  = (w_state_nxt == S_FETCH) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_CHECK) || (w_state_nxt == S_RETRY);
        w_ok_nxt    = (w_state_nxt == S_PASS);
        w_fail_nxt  = (w_state_nxt == S_LOCK);
    end

    assign fw_rd_en    = r_rd_en;
    assign fw_addr     = r_addr;
    assign boot_busy   = r_busy;
    assign boot_ok     = r_ok;
    assign boot_fail   = r_fail;
    assign attempt_cnt = r_attempt;

endmodule
